// File: rtl/idex_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// idex_operand_stage_pkg
// Shared types for the ID/EX operand stage: datapath word and register-index
// widths, ALU opcode encoding, forwarding-source select and the bubble opcode.
// No ports (package).
// ---------------------------------------------------------------------------
package idex_operand_stage_pkg;

  localparam int WORD_W  = 32;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [REG_W-1:0]   regbits_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // A bubble carries opcode encoding 0.
  localparam aluop_t BUBBLE_ALUOP = ALU_SLL;

  // A later stage can supply a source operand only if it writes a
  // non-zero register that matches the source index ($zero is hard-wired).
  function automatic logic fwd_hit(input logic     regwrite,
                                   input regbits_t rd,
                                   input regbits_t src);
    return regwrite && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/idex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// idex_operand_stage_if
// Bundle between decode / forwarding sources and the ID/EX operand stage.
//   en/flush      : pipeline control (flush beats en; en=0 holds)
//   id_*          : decoded instruction presented for capture
//   exmem_*/memwb_*: forwarding sources, consumed combinationally
//   ex_*          : registered EX-side outputs and ALU operands
//   load_use      : combinational stall request for the hazard unit
// Handshake: there is no valid/ready pair. A decoded instruction is accepted
// on every rising edge where en=1 and flush=0; the hazard unit throttles the
// stage by dropping en or raising flush. id_valid/ex_valid only mark whether
// the slot holds a real instruction.
// Modports: master = surrounding pipeline, slave = operand stage.
// ---------------------------------------------------------------------------
interface idex_operand_stage_if;
  import idex_operand_stage_pkg::*;

  logic     en;
  logic     flush;

  logic     id_valid;
  logic     id_regwrite;
  logic     id_memread;
  logic     id_alusrc;
  logic     id_shiftsel;
  aluop_t   id_aluop;
  word_t    id_rs_data;
  word_t    id_rt_data;
  word_t    id_imm;
  regbits_t id_rs;
  regbits_t id_rt;
  regbits_t id_rd;
  shamt_t   id_shamt;

  logic     exmem_regwrite;
  regbits_t exmem_rd;
  word_t    exmem_data;
  logic     memwb_regwrite;
  regbits_t memwb_rd;
  word_t    memwb_data;

  logic     ex_valid;
  logic     ex_regwrite;
  logic     ex_memread;
  regbits_t ex_rd;
  aluop_t   ex_aluop;
  word_t    ex_portA;
  word_t    ex_portB;
  word_t    ex_store_data;
  logic     load_use;

  modport master (
    output en, flush,
    output id_valid, id_regwrite, id_memread, id_alusrc, id_shiftsel, id_aluop,
    output id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_shamt,
    output exmem_regwrite, exmem_rd, exmem_data,
    output memwb_regwrite, memwb_rd, memwb_data,
    input  ex_valid, ex_regwrite, ex_memread, ex_rd, ex_aluop,
    input  ex_portA, ex_portB, ex_store_data, load_use
  );

  modport slave (
    input  en, flush,
    input  id_valid, id_regwrite, id_memread, id_alusrc, id_shiftsel, id_aluop,
    input  id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_shamt,
    input  exmem_regwrite, exmem_rd, exmem_data,
    input  memwb_regwrite, memwb_rd, memwb_data,
    output ex_valid, ex_regwrite, ex_memread, ex_rd, ex_aluop,
    output ex_portA, ex_portB, ex_store_data, load_use
  );
endinterface

// File: rtl/idex_operand_stage_forward_unit.sv
// ---------------------------------------------------------------------------
// idex_operand_stage_forward_unit
// Purely combinational forwarding-source select for one source operand.
//   i_reg                       : source register index held in ID/EX
//   i_exmem_regwrite/i_exmem_rd : EX/MEM writer
//   i_memwb_regwrite/i_memwb_rd : MEM/WB writer
//   o_sel                       : FWD_EXMEM / FWD_MEMWB / FWD_REG
// EX/MEM is the younger result, so it wins when both stages match.
// FWD_EN=0 pins the select to the captured register value.
// ---------------------------------------------------------------------------
module idex_operand_stage_forward_unit
  import idex_operand_stage_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  regbits_t i_reg,
  input  logic     i_exmem_regwrite,
  input  regbits_t i_exmem_rd,
  input  logic     i_memwb_regwrite,
  input  regbits_t i_memwb_rd,
  output fwd_sel_t o_sel
);

  always_comb begin
    o_sel = FWD_REG;
    if (FWD_EN) begin
      if (fwd_hit(i_exmem_regwrite, i_exmem_rd, i_reg)) begin
        o_sel = FWD_EXMEM;
      end else if (fwd_hit(i_memwb_regwrite, i_memwb_rd, i_reg)) begin
        o_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/idex_operand_stage.sv
// ---------------------------------------------------------------------------
// idex_operand_stage
// ID/EX pipeline register plus ALU operand delivery.
//   CLK   : rising-edge clock
//   nRST  : asynchronous active-low reset (loads a bubble)
//   bus   : idex_operand_stage_if.slave (controls, id_*, forwarding
//           sources in; ex_*, ALU ports, load_use out)
// Edge priority: reset > flush > en > hold. ALU operands are formed
// combinationally from the registered instruction and the live forwarding
// inputs, so they keep tracking EX/MEM and MEM/WB while the stage holds.
// ---------------------------------------------------------------------------
module idex_operand_stage
  import idex_operand_stage_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input logic              CLK,
  input logic              nRST,
  idex_operand_stage_if.slave bus
);

  logic     r_valid;
  logic     r_regwrite;
  logic     r_memread;
  logic     r_alusrc;
  logic     r_shiftsel;
  aluop_t   r_aluop;
  word_t    r_rs_data;
  word_t    r_rt_data;
  word_t    r_imm;
  regbits_t r_rs;
  regbits_t r_rt;
  regbits_t r_rd;
  shamt_t   r_shamt;

  fwd_sel_t w_sel_a;
  fwd_sel_t w_sel_b;
  word_t    w_fa;
  word_t    w_fb;

  // Pipeline register. A flush always loads a full bubble (data included)
  // so nothing stale can leak into the ALU ports.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_alusrc   <= 1'b0;
      r_shiftsel <= 1'b0;
      r_aluop    <= BUBBLE_ALUOP;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_shamt    <= '0;
    end else if (bus.flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_alusrc   <= 1'b0;
      r_shiftsel <= 1'b0;
      r_aluop    <= BUBBLE_ALUOP;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_shamt    <= '0;
    end else if (bus.en) begin
      r_valid    <= bus.id_valid;
      r_regwrite <= bus.id_regwrite;
      r_memread  <= bus.id_memread;
      r_alusrc   <= bus.id_alusrc;
      r_shiftsel <= bus.id_shiftsel;
      r_aluop    <= bus.id_aluop;
      r_rs_data  <= bus.id_rs_data;
      r_rt_data  <= bus.id_rt_data;
      r_imm      <= bus.id_imm;
      r_rs       <= bus.id_rs;
      r_rt       <= bus.id_rt;
      r_rd       <= bus.id_rd;
      r_shamt    <= bus.id_shamt;
    end
  end

  idex_operand_stage_forward_unit #(.FWD_EN(FWD_EN)) u_fwd_rs (
    .i_reg            (r_rs),
    .i_exmem_regwrite (bus.exmem_regwrite),
    .i_exmem_rd       (bus.exmem_rd),
    .i_memwb_regwrite (bus.memwb_regwrite),
    .i_memwb_rd       (bus.memwb_rd),
    .o_sel            (w_sel_a)
  );

  idex_operand_stage_forward_unit #(.FWD_EN(FWD_EN)) u_fwd_rt (
    .i_reg            (r_rt),
    .i_exmem_regwrite (bus.exmem_regwrite),
    .i_exmem_rd       (bus.exmem_rd),
    .i_memwb_regwrite (bus.memwb_regwrite),
    .i_memwb_rd       (bus.memwb_rd),
    .o_sel            (w_sel_b)
  );

  always_comb begin
    w_fa = r_rs_data;
    case (w_sel_a)
      FWD_EXMEM: w_fa = bus.exmem_data;
      FWD_MEMWB: w_fa = bus.memwb_data;
      default:   w_fa = r_rs_data;
    endcase
  end

  always_comb begin
    w_fb = r_rt_data;
    case (w_sel_b)
      FWD_EXMEM: w_fb = bus.exmem_data;
      FWD_MEMWB: w_fb = bus.memwb_data;
      default:   w_fb = r_rt_data;
    endcase
  end

  assign bus.ex_valid      = r_valid;
  assign bus.ex_regwrite   = r_regwrite;
  assign bus.ex_memread    = r_memread;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_aluop      = r_aluop;
  assign bus.ex_portA      = r_shiftsel ? {{(WORD_W-SHAMT_W){1'b0}}, r_shamt} : w_fa;
  assign bus.ex_portB      = r_alusrc ? r_imm : w_fb;
  // Stores always need the register value, even when portB carries the offset.
  assign bus.ex_store_data = w_fb;

  // A load in EX whose destination is read by the instruction in ID cannot
  // be forwarded in time; request one stall cycle.
  assign bus.load_use = r_valid && r_memread && (r_rd != '0) && bus.id_valid &&
                        ((r_rd == bus.id_rs) || (r_rd == bus.id_rt));

endmodule
